branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
Sequencer that owns the condition comparator (cond ALU) and resolves one conditional branch at a time for the decode stage. It accepts a branch over a valid/ready handshake and holds it until its operands are forwarded. It then drives the comparator, samples its z_flag, and on a taken branch issues a one-cycle redirect followed by a fixed-length pipeline flush. It also keeps saturating branch/taken counters for performance monitoring.

Parameters:
FLUSH_CYCLES, 2, cycles flush is held after a taken branch (legal range 1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
br_valid  in  1  decode presents a branch
br_ready  out  1  controller can accept a branch (high only in IDLE)
br_op  in  4  condition code, `ALU_*` encodings from params.v
br_opa  in  32  operand A (signed)
br_opb  in  32  operand B (signed)
br_ops_ready  in  1  br_opa/br_opb hold valid forwarded values this cycle
br_target  in  32  branch target PC
br_kill  in  1  later-stage squash of the in-flight branch
cond_op  out  4  to comparator op
cond_opa  out  32  to comparator opa
cond_opb  out  32  to comparator opb
cond_z  in  1  comparator z_flag (combinational from cond_op/opa/opb)
stall  out  1  hold decode; high whenever state != IDLE
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  32  taken-branch target
flush  out  1  squash younger instructions
br_count  out  CNT_W  resolved branches, saturating
taken_count  out  CNT_W  taken branches, saturating

Behaviour:
- States: IDLE, WAIT, EVAL, FLUSH. Reset -> IDLE.
- Reset values: all registers and outputs 0 (cond_*, redirect_pc, counters, flush, redirect_valid); br_ready=1, stall=0 after reset.
- IDLE: br_ready=1. br_valid=1 -> latch op and target. If br_ops_ready=1 also latch opa/opb -> EVAL, else -> WAIT.
- WAIT: re-check br_ops_ready every cycle. On the cycle it is 1, latch br_opa/br_opb -> EVAL. Stay in WAIT indefinitely otherwise.
- cond_op/cond_opa/cond_opb are driven from the latched registers. Values stay stable from latch until the next accept.
- EVAL (exactly 1 cycle): taken = cond_z, with two overrides: `ALU_T` is always taken and `ALU_F` is never taken, regardless of cond_z. br_count increments.
  - Taken: taken_count increments, redirect_pc <= target -> FLUSH.
  - Not taken: -> IDLE.
- FLUSH: flush=1 for exactly FLUSH_CYCLES cycles. redirect_valid=1 only in the first FLUSH cycle. Then -> IDLE.
- Latency, ops ready at accept cycle T:
  - EVAL at T+1.
  - Taken: redirect_valid at T+2, br_ready again at T+2+FLUSH_CYCLES.
  - Not taken: br_ready at T+2.
- br_kill: in WAIT or EVAL -> IDLE next cycle with no redirect, no flush and no counter update. Kill wins over a simultaneous EVAL resolution. Ignored in IDLE and FLUSH.
- Counters: saturate at all-ones and never wrap. br_count and taken_count update in the same cycle.
- Undefined op codes: taken follows cond_z; the comparator returns 0 for undefined codes.
- rst mid-operation: abandon state, no redirect/flush emitted, counters cleared.
- br_valid while br_ready=0: ignored, not queued. Decode is held by stall.

Test Plan:
1. Reset, then accept `ALU_EQ` with opa=5, opb=5, ops ready, target=0x100 -> EVAL next cycle; redirect_valid=1 with redirect_pc=0x100 two cycles after accept; flush high 2 cycles; br_count=1, taken_count=1.
2. `ALU_LT` with opa=-3, opb=-7 (cond_z=0) -> no redirect, no flush; br_ready back 2 cycles after accept; br_count=1, taken_count=0.
3. Accept `ALU_GTZ` with br_ops_ready=0 for 4 cycles, then ops ready with opa=1 -> stall high throughout WAIT; operands latched only on the ready cycle; taken, redirect issued.
4. `ALU_T` with cond_z forced 0 -> taken; `ALU_F` with cond_z forced 1 -> not taken.
5. br_kill asserted in WAIT, and separately in the EVAL cycle of a taken branch -> IDLE next cycle; redirect_valid/flush never asserted; counters unchanged.
6. CNT_W=4: 17 taken branches -> both counters saturate at 15. Then assert rst during FLUSH -> flush drops next cycle, counters read 0, br_ready=1.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl -- resolves one conditional branch at a time for decode.
//
// Accepts a branch over a valid/ready handshake and holds it until its
// operands have been forwarded. It then drives the external condition
// comparator for one cycle and samples its z flag. A taken branch produces a
// one-cycle redirect followed by a flush of FLUSH_CYCLES cycles. Saturating
// counters track resolved and taken branches.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   br_valid/ready    branch handshake from decode (ready only when idle)
//   br_op             condition code (ALU_* encoding below)
//   br_opa, br_opb    signed operands, valid when br_ops_ready is high
//   br_ops_ready      operands hold forwarded values this cycle
//   br_target         branch target PC
//   br_kill           squash of the in-flight branch from a later stage
//   cond_op/opa/opb   latched branch, driven to the comparator
//   cond_z            comparator result (combinational from cond_*)
//   stall             hold decode while a branch is in flight
//   redirect_valid    one-cycle pulse: fetch loads redirect_pc
//   redirect_pc       target of the last taken branch
//   flush             squash younger instructions
//   br_count          resolved branches, saturating
//   taken_count       taken branches, saturating

module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_op,
  input  logic [31:0]      br_opa,
  input  logic [31:0]      br_opb,
  input  logic             br_ops_ready,
  input  logic [31:0]      br_target,
  input  logic             br_kill,
  output logic [3:0]       cond_op,
  output logic [31:0]      cond_opa,
  output logic [31:0]      cond_opb,
  input  logic             cond_z,
  output logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  // Condition-code encodings shared with the comparator.
  localparam logic [3:0] ALU_T   = 4'd6;
  localparam logic [3:0] ALU_F   = 4'd7;
  localparam logic [3:0] ALU_EQ  = 4'd8;
  localparam logic [3:0] ALU_NE  = 4'd9;
  localparam logic [3:0] ALU_LT  = 4'd10;
  localparam logic [3:0] ALU_GE  = 4'd11;
  localparam logic [3:0] ALU_LTZ = 4'd12;
  localparam logic [3:0] ALU_GEZ = 4'd13;
  localparam logic [3:0] ALU_GTZ = 4'd14;
  localparam logic [3:0] ALU_LEZ = 4'd15;

  // Flush counter is loaded with the number of flush cycles still to go
  // after the current one.
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_EVAL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t           state_reg;
  logic [3:0]       op_reg;
  logic [31:0]      opa_reg;
  logic [31:0]      opb_reg;
  logic [31:0]      target_reg;
  logic [31:0]      redirect_pc_reg;
  logic             redirect_valid_reg;
  logic             flush_reg;
  logic [3:0]       flush_cnt_reg;
  logic [CNT_W-1:0] br_count_reg;
  logic [CNT_W-1:0] taken_count_reg;
  logic             taken;

  // Unconditional codes override the comparator; everything else (including
  // undefined codes, for which the comparator reports 0) follows cond_z.
  always_comb begin
    taken = cond_z;
    case (op_reg)
      ALU_T:   taken = 1'b1;
      ALU_F:   taken = 1'b0;
      default: taken = cond_z;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= S_IDLE;
      op_reg             <= '0;
      opa_reg            <= '0;
      opb_reg            <= '0;
      target_reg         <= '0;
      redirect_pc_reg    <= '0;
      redirect_valid_reg <= 1'b0;
      flush_reg          <= 1'b0;
      flush_cnt_reg      <= '0;
      br_count_reg       <= '0;
      taken_count_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (br_valid) begin
            op_reg     <= br_op;
            target_reg <= br_target;
            if (br_ops_ready) begin
              opa_reg   <= br_opa;
              opb_reg   <= br_opb;
              state_reg <= S_EVAL;
            end else begin
              state_reg <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // A kill abandons the branch even if operands arrive this cycle.
          if (br_kill) begin
            state_reg <= S_IDLE;
          end else if (br_ops_ready) begin
            opa_reg   <= br_opa;
            opb_reg   <= br_opb;
            state_reg <= S_EVAL;
          end
        end

        S_EVAL: begin
          // Kill takes priority over resolution: no counters, no redirect.
          if (br_kill) begin
            state_reg <= S_IDLE;
          end else begin
            if (br_count_reg != CNT_MAX) begin
              br_count_reg <= br_count_reg + CNT_W'(1);
            end
            if (taken) begin
              if (taken_count_reg != CNT_MAX) begin
                taken_count_reg <= taken_count_reg + CNT_W'(1);
              end
              redirect_pc_reg    <= target_reg;
              redirect_valid_reg <= 1'b1;
              flush_reg          <= 1'b1;
              flush_cnt_reg      <= FLUSH_LAST;
              state_reg          <= S_FLUSH;
            end else begin
              state_reg <= S_IDLE;
            end
          end
        end

        S_FLUSH: begin
          // Redirect is only valid in the first flush cycle.
          redirect_valid_reg <= 1'b0;
          if (flush_cnt_reg == 4'd0) begin
            flush_reg <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 4'd1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign br_ready       = (state_reg == S_IDLE);
  assign stall          = (state_reg != S_IDLE);
  assign cond_op        = op_reg;
  assign cond_opa       = opa_reg;
  assign cond_opb       = opb_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign flush          = flush_reg;
  assign br_count       = br_count_reg;
  assign taken_count    = taken_count_reg;

  // Encodings evaluated by the external comparator only; listed here so the
  // full code map lives next to the overrides above.
  logic unused_codes;
  assign unused_codes = ^{ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTZ, ALU_GEZ, ALU_GTZ, ALU_LEZ};

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;

  localparam logic [3:0] ALU_T   = 4'd6;
  localparam logic [3:0] ALU_F   = 4'd7;
  localparam logic [3:0] ALU_EQ  = 4'd8;
  localparam logic [3:0] ALU_NE  = 4'd9;
  localparam logic [3:0] ALU_LT  = 4'd10;
  localparam logic [3:0] ALU_GE  = 4'd11;
  localparam logic [3:0] ALU_LTZ = 4'd12;
  localparam logic [3:0] ALU_GEZ = 4'd13;
  localparam logic [3:0] ALU_GTZ = 4'd14;
  localparam logic [3:0] ALU_LEZ = 4'd15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             br_valid = 1'b0;
  logic             br_ready;
  logic [3:0]       br_op = '0;
  logic [31:0]      br_opa = '0;
  logic [31:0]      br_opb = '0;
  logic             br_ops_ready = 1'b0;
  logic [31:0]      br_target = '0;
  logic             br_kill = 1'b0;
  logic [3:0]       cond_op;
  logic [31:0]      cond_opa;
  logic [31:0]      cond_opb;
  logic             cond_z;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  logic force_en  = 1'b0;
  logic force_val = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  int          flush_run = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_op(br_op), .br_opa(br_opa), .br_opb(br_opb),
    .br_ops_ready(br_ops_ready), .br_target(br_target), .br_kill(br_kill),
    .cond_op(cond_op), .cond_opa(cond_opa), .cond_opb(cond_opb), .cond_z(cond_z),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .br_count(br_count), .taken_count(taken_count)
  );

  // Reference comparator: z = 1 when the condition holds, 0 for undefined codes.
  function automatic logic cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_EQ:  return a == b;
      ALU_NE:  return a != b;
      ALU_LT:  return $signed(a) < $signed(b);
      ALU_GE:  return $signed(a) >= $signed(b);
      ALU_LTZ: return $signed(a) < 0;
      ALU_GEZ: return $signed(a) >= 0;
      ALU_GTZ: return $signed(a) > 0;
      ALU_LEZ: return $signed(a) <= 0;
      default: return 1'b0;
    endcase
  endfunction

  assign cond_z = force_en ? force_val : cmp(cond_op, cond_opa, cond_opb);

  // Scoreboard monitor: pops an expected target for every redirect pulse and
  // checks that each flush burst starts with the redirect and has the full length.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_redirect: got unexpected redirect pc=%h, required none", redirect_pc);
      end else begin
        logic [31:0] pc;
        pc = exp_q.pop_front();
        if (redirect_pc !== pc || flush !== 1'b1 || flush_run != 0) begin
          tests_failed++;
          $display("FAIL sb_redirect: got pc=%h flush=%0b run=%0d, required pc=%h flush=1 run=0",
                   redirect_pc, flush, flush_run, pc);
        end
      end
    end
    if (flush === 1'b1) begin
      if (flush_run == 0) begin
        tests_run++;
        if (redirect_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL sb_flush_start: got redirect_valid=%0b at flush start, required 1", redirect_valid);
        end
      end
      flush_run++;
    end else if (flush_run != 0) begin
      if (rst !== 1'b1) begin
        tests_run++;
        if (flush_run != FLUSH_CYCLES) begin
          tests_failed++;
          $display("FAIL sb_flush_len: got %0d cycles, required %0d", flush_run, FLUSH_CYCLES);
        end
      end
      flush_run = 0;
    end
  end

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1; br_valid = 1'b0; br_ops_ready = 1'b0; br_kill = 1'b0;
    br_op = '0; br_opa = '0; br_opb = '0; br_target = '0; force_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_branch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] tgt, input logic rdy);
    tests_run++;
    if (br_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept_ready: got br_ready=%0b, required 1", br_ready);
    end
    br_valid = 1'b1; br_op = op; br_opa = a; br_opb = b; br_target = tgt; br_ops_ready = rdy;
    $display("[TB] branch op=%0d opa=%0d opb=%0d target=%h ops_ready=%0b",
             op, $signed(a), $signed(b), tgt, rdy);
  endtask

  task automatic wait_ready;
    int n = 0;
    while (br_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (br_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_ready: got br_ready=%0b after %0d cycles, required 1", br_ready, n);
    end
  endtask

  task automatic test_reset;
    apply_reset;
    tests_run++;
    if (br_ready !== 1'b1 || stall !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got ready=%0b stall=%0b flush=%0b redir=%0b, required 1 0 0 0",
               br_ready, stall, flush, redirect_valid);
    end
    tests_run++;
    if ({cond_op, cond_opa, cond_opb, redirect_pc, br_count, taken_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: got op=%h opa=%h opb=%h pc=%h bc=%0d tc=%0d, required all 0",
               cond_op, cond_opa, cond_opb, redirect_pc, br_count, taken_count);
    end
  endtask

  task automatic test_taken_eq;
    apply_reset;
    drive_branch(ALU_EQ, 32'd5, 32'd5, 32'h100, 1'b1);
    exp_q.push_back(32'h100);
    @(negedge clk);  // EVAL
    br_valid = 1'b0; br_ops_ready = 1'b0;
    tests_run++;
    if (stall !== 1'b1 || br_ready !== 1'b0 || cond_op !== ALU_EQ || cond_opa !== 32'd5 || cond_opb !== 32'd5) begin
      tests_failed++;
      $display("FAIL eq_eval: got stall=%0b ready=%0b op=%0d opa=%0d opb=%0d, required 1 0 %0d 5 5",
               stall, br_ready, cond_op, cond_opa, cond_opb, ALU_EQ);
    end
    @(negedge clk);  // first FLUSH cycle
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100 || flush !== 1'b1) begin
      tests_failed++;
      $display("FAIL eq_redirect: got redir=%0b pc=%h flush=%0b, required 1 00000100 1",
               redirect_valid, redirect_pc, flush);
    end
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b0 || flush !== 1'b1 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL eq_flush2: got redir=%0b flush=%0b stall=%0b, required 0 1 1", redirect_valid, flush, stall);
    end
    @(negedge clk);
    tests_run++;
    if (br_ready !== 1'b1 || flush !== 1'b0 || br_count !== 4'd1 || taken_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL eq_done: got ready=%0b flush=%0b bc=%0d tc=%0d, required 1 0 1 1",
               br_ready, flush, br_count, taken_count);
    end
  endtask

  task automatic test_not_taken_lt;
    apply_reset;
    drive_branch(ALU_LT, -32'sd3, -32'sd7, 32'h180, 1'b1);
    @(negedge clk);
    br_valid = 1'b0; br_ops_ready = 1'b0;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL lt_eval: got stall=%0b, required 1", stall);
    end
    @(negedge clk);
    tests_run++;
    if (br_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0 || br_count !== 4'd1 || taken_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL lt_done: got ready=%0b flush=%0b redir=%0b bc=%0d tc=%0d, required 1 0 0 1 0",
               br_ready, flush, redirect_valid, br_count, taken_count);
    end
  endtask

  task automatic test_wait_operands;
    apply_reset;
    drive_branch(ALU_GTZ, -32'sd9, 32'd0, 32'h200, 1'b0);
    exp_q.push_back(32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // Keep presenting a different branch: it must be ignored while busy.
      br_valid = 1'b1; br_op = ALU_EQ; br_target = 32'h999; br_opa = -32'sd9 - i;
      tests_run++;
      if (stall !== 1'b1 || br_ready !== 1'b0 || cond_opa !== 32'd0 || cond_op !== ALU_GTZ) begin
        tests_failed++;
        $display("FAIL wait_hold[%0d]: got stall=%0b ready=%0b opa=%h op=%0d, required 1 0 0 %0d",
                 i, stall, br_ready, cond_opa, cond_op, ALU_GTZ);
      end
    end
    @(negedge clk);
    br_valid = 1'b0; br_ops_ready = 1'b1; br_opa = 32'd1;
    @(negedge clk);  // EVAL
    br_ops_ready = 1'b0; br_opa = 32'hDEAD_BEEF;
    tests_run++;
    if (cond_opa !== 32'd1 || cond_op !== ALU_GTZ || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_latch: got opa=%h op=%0d stall=%0b, required 00000001 %0d 1",
               cond_opa, cond_op, stall, ALU_GTZ);
    end
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
      tests_failed++;
      $display("FAIL wait_redirect: got redir=%0b pc=%h, required 1 00000200", redirect_valid, redirect_pc);
    end
    wait_ready;
    tests_run++;
    if (br_count !== 4'd1 || taken_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL wait_counts: got bc=%0d tc=%0d, required 1 1", br_count, taken_count);
    end
  endtask

  task automatic test_overrides;
    apply_reset;
    force_en = 1'b1; force_val = 1'b0;
    drive_branch(ALU_T, 32'd0, 32'd0, 32'h300, 1'b1);
    exp_q.push_back(32'h300);
    @(negedge clk);
    br_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
      tests_failed++;
      $display("FAIL alu_t: got redir=%0b pc=%h, required 1 00000300", redirect_valid, redirect_pc);
    end
    wait_ready;
    force_val = 1'b1;
    drive_branch(ALU_F, 32'd0, 32'd0, 32'h400, 1'b1);
    @(negedge clk);
    br_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || br_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL alu_f: got redir=%0b flush=%0b ready=%0b, required 0 0 1", redirect_valid, flush, br_ready);
    end
    tests_run++;
    if (br_count !== 4'd2 || taken_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL override_counts: got bc=%0d tc=%0d, required 2 1", br_count, taken_count);
    end
    force_en = 1'b0;
  endtask

  task automatic test_kill;
    apply_reset;
    drive_branch(ALU_EQ, 32'd1, 32'd1, 32'h500, 1'b0);
    @(negedge clk);  // WAIT; operands arrive together with the kill
    br_valid = 1'b0; br_kill = 1'b1; br_ops_ready = 1'b1;
    @(negedge clk);
    br_kill = 1'b0; br_ops_ready = 1'b0;
    tests_run++;
    if (br_ready !== 1'b1 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL kill_wait: got ready=%0b stall=%0b, required 1 0", br_ready, stall);
    end
    drive_branch(ALU_EQ, 32'd7, 32'd7, 32'h600, 1'b1);
    @(negedge clk);  // EVAL of a branch that would be taken
    br_valid = 1'b0; br_ops_ready = 1'b0; br_kill = 1'b1;
    @(negedge clk);
    br_kill = 1'b0;
    tests_run++;
    if (br_ready !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
      tests_failed++;
      $display("FAIL kill_eval: got ready=%0b redir=%0b flush=%0b, required 1 0 0", br_ready, redirect_valid, flush);
    end
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b0 || br_count !== 4'd0 || taken_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL kill_counts: got flush=%0b bc=%0d tc=%0d, required 0 0 0", flush, br_count, taken_count);
    end
  endtask

  task automatic test_back_to_back_saturate;
    apply_reset;
    for (int i = 0; i < 17; i++) begin
      drive_branch(ALU_EQ, i, i, 32'h1000 + 4 * i, 1'b1);
      exp_q.push_back(32'h1000 + 4 * i);
      @(negedge clk);
      br_valid = 1'b0; br_ops_ready = 1'b0;
      wait_ready;
    end
    tests_run++;
    if (br_count !== 4'd15 || taken_count !== 4'd15) begin
      tests_failed++;
      $display("FAIL saturate: got bc=%0d tc=%0d, required 15 15", br_count, taken_count);
    end
    drive_branch(ALU_EQ, 32'd3, 32'd3, 32'h700, 1'b1);
    exp_q.push_back(32'h700);
    @(negedge clk);
    br_valid = 1'b0; br_ops_ready = 1'b0;
    @(negedge clk);  // first FLUSH cycle: reset arrives here
    tests_run++;
    if (flush !== 1'b1 || br_count !== 4'd15 || taken_count !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_hold: got flush=%0b bc=%0d tc=%0d, required 1 15 15", flush, br_count, taken_count);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0 || br_ready !== 1'b1 || br_count !== 4'd0 || taken_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_in_flush: got flush=%0b redir=%0b ready=%0b bc=%0d tc=%0d, required 0 0 1 0 0",
               flush, redirect_valid, br_ready, br_count, taken_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (flush !== 1'b0 || br_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_after: got flush=%0b ready=%0b, required 0 1", flush, br_ready);
    end
  endtask

  initial begin
    test_reset;
    test_taken_eq;
    test_not_taken_lt;
    test_wait_operands;
    test_overrides;
    test_kill;
    test_back_to_back_saturate;
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d redirects outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
